mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Arbiter and sequencer for the unified single-port instruction/data block RAM.
- Shares the one memory port between the fetch requester (PC) and the load/store requester.
- Issues at most one access per cycle and tracks the one-cycle synchronous read latency.
- Returns data to the correct requester and generates the fetch stall.
- Sits between the core pipeline and the RAM instance.

Parameters:
ADDR_WIDTH, 12, word-address bits of the RAM (depth 2**ADDR_WIDTH words)
DATA_WIDTH, 32, word width
STARVE_LIMIT, 4, max consecutive data grants while fetch waits before fetch is forced (1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request
if_addr  in  32  fetch byte address (PC); word index = if_addr[ADDR_WIDTH+1:2]
if_flush  in  1  jump/flush; kills any fetch in flight
if_gnt  out  1  fetch accepted this cycle (combinational)
if_valid  out  1  fetch data valid
if_inst  out  DATA_WIDTH  instruction; 0 (NOP) when if_valid=0
stall  out  1  if_req & ~if_gnt
d_req  in  1  data request
d_we  in  1  1=store, 0=load
d_addr  in  32  data byte address
d_wdata  in  DATA_WIDTH  store data
d_gnt  out  1  data accepted this cycle (combinational)
d_rvalid  out  1  load data valid
d_rdata  out  DATA_WIDTH  load data; 0 when d_rvalid=0
d_err  out  1  address error pulse (see Optional Feature)
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_WIDTH  RAM word address
mem_wdata  out  DATA_WIDTH  RAM write data
mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after a read issue

Behaviour:
- Reset (async assert, sync release): if_valid=0, d_rvalid=0, d_err=0, resp_src=NONE, starve_cnt=0. if_inst and d_rdata read 0.
- Grant rule, evaluated every cycle, combinational:
  - data wins, unless if_req & d_req & starve_cnt==STARVE_LIMIT, in which case fetch wins.
  - single requester is always granted; no request gives mem_en=0.
- mem_en=if_gnt|d_gnt. mem_we=d_gnt&d_we. mem_addr/mem_wdata taken from the granted requester. Address low 2 bits dropped; upper bits truncated.
- starve_cnt:
  - +1 on each data grant while if_req=1, saturating at STARVE_LIMIT.
  - Cleared on any fetch grant, or any cycle with if_req=0.
- Response tracker resp_src {NONE, IF, DATA}, registered each cycle:
  - IF if fetch granted and if_flush=0.
  - DATA if a load is granted.
  - else NONE.
  - A store never creates a response.
- Latency: grant in cycle N, then if_valid/d_rvalid=1 in cycle N+1 with data = mem_rdata passed through. Exactly 1 cycle; no back-pressure on responses.
- if_valid = (resp_src==IF) & ~if_flush. A flush in the issue cycle or the return cycle kills the fetch; if_inst=0.
- Flush does not affect data responses or starve_cnt.
- Back-to-back grants every cycle are fully pipelined.
- Store then load to the same address in consecutive cycles: the load returns the new data (RAM write-first not required; the store completes in cycle N, the read is issued in N+1).
- Reset mid-operation: in-flight response discarded, no valid pulse after release.

Optional Feature:
Macro MEM_ARB_ADDR_CHECK_EN.
- Defined:
  - A granted data access is an error if d_addr[1:0]!=0 or d_addr[31:ADDR_WIDTH+2]!=0.
  - On error: mem_en=0 for it, and d_gnt is still asserted.
  - Next cycle: d_err=1 for one cycle; for a load, also d_rvalid=1 with d_rdata=0.
  - An erroring store writes nothing.
- Undefined: d_err tied 0; addresses truncated as above; no checks.

Test Plan:
- Reset with if_req=1, if_addr=0x0: next cycle if_gnt=1, mem_addr=0. Following cycle if_valid=1, if_inst=RAM[0].
- Store d_addr=0x40, d_wdata=0xDEADBEEF, then load d_addr=0x40 next cycle, with if_req=1 throughout: stall=1 for both cycles. Load gives d_rvalid=1, d_rdata=0xDEADBEEF. Fetch resumes after.
- Starvation, STARVE_LIMIT=4: d_req=1 and if_req=1 held continuously. Grant pattern is D,D,D,D,I repeating; stall=0 only in the I cycles.
- Fetch issued in N, if_flush=1 in N+1: if_valid=0, if_inst=0. New fetch of 0x100 in N+1 returns RAM[0x40] in N+2.
- Assert rst_n=0 asynchronously the cycle after a load grant: d_rvalid stays 0 during and after reset, starve_cnt=0.
- With MEM_ARB_ADDR_CHECK_EN, load d_addr=0x4002: mem_en=0, next cycle d_err=1, d_rvalid=1, d_rdata=0. Without the macro, RAM word 0x000 is read and d_err=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port unified instruction/data RAM between
// the fetch requester and the load/store requester.
//   - At most one RAM access per cycle. Data wins unless fetch has waited
//     STARVE_LIMIT consecutive data grants, in which case fetch is forced.
//   - Tracks the one-cycle read latency and steers mem_rdata back to the
//     requester that issued the read. if_flush kills a fetch at issue or return.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   if_req/if_addr/if_flush          fetch request, PC byte address, flush
//   if_gnt, stall                    fetch accepted / fetch stalled (comb)
//   if_valid/if_inst                 fetch response (inst is 0 when invalid)
//   d_req/d_we/d_addr/d_wdata        load/store request
//   d_gnt                            data accepted (comb)
//   d_rvalid/d_rdata/d_err           load response, address-error pulse
//   mem_en/mem_we/mem_addr/mem_wdata RAM command (comb)
//   mem_rdata                        RAM read data, one cycle after issue
// Optional build macro MEM_ARB_ADDR_CHECK_EN: misaligned or out-of-range data
// accesses are granted but not sent to the RAM, and raise d_err next cycle
// (a load also returns d_rvalid with zero data). Without it d_err is 0 and
// addresses are simply truncated to the RAM word index.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  input  logic                  if_flush,
  output logic                  if_gnt,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_inst,
  output logic                  stall,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_DATA = 2'd2
  } resp_e;

  resp_e            resp_src, resp_next;
  logic [CNT_W-1:0] starve_cnt, starve_next;
  logic             err_q, err_next;
  logic             force_if;
  logic             d_bad;
  logic             unused_addr_bits;

  // Byte-address bits that never reach the RAM in the default build.
  assign unused_addr_bits = ^{if_addr[31:ADDR_WIDTH+2], if_addr[1:0],
                              d_addr[31:ADDR_WIDTH+2], d_addr[1:0]};

  // State register: response tracker, starvation counter, error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_src   <= RESP_NONE;
      starve_cnt <= '0;
      err_q      <= 1'b0;
    end else begin
      resp_src   <= resp_next;
      starve_cnt <= starve_next;
      err_q      <= err_next;
    end
  end

  // Grant, RAM command, next tracker state and response steering.
  always_comb begin
    resp_next   = RESP_NONE;
    starve_next = '0;
    err_next    = 1'b0;
    d_bad       = 1'b0;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    stall       = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = if_addr[ADDR_WIDTH+1:2];
    mem_wdata   = d_wdata;
    if_valid    = 1'b0;
    if_inst     = '0;
    d_rvalid    = 1'b0;
    d_rdata     = '0;
    d_err       = err_q;

    force_if = if_req & d_req & (starve_cnt == CNT_W'(STARVE_LIMIT));
    d_gnt    = d_req & ~force_if;
    if_gnt   = if_req & ~d_gnt;
    stall    = if_req & ~if_gnt;

`ifdef MEM_ARB_ADDR_CHECK_EN
    d_bad = d_gnt & ((d_addr[1:0] != 2'b00) | (d_addr[31:ADDR_WIDTH+2] != '0));
`endif

    // An erroring data access still owns the cycle but never touches the RAM.
    mem_en   = if_gnt | (d_gnt & ~d_bad);
    mem_we   = d_gnt & d_we & ~d_bad;
    if (d_gnt) mem_addr = d_addr[ADDR_WIDTH+1:2];
    err_next = d_bad;

    if (d_gnt && !d_we)           resp_next = RESP_DATA;
    else if (if_gnt && !if_flush) resp_next = RESP_IF;

    // Counts data grants that made a waiting fetch lose; any fetch grant or
    // idle fetch cycle restarts the count.
    if (if_req && !if_gnt) begin
      starve_next = starve_cnt;
      if (d_gnt && (starve_cnt < CNT_W'(STARVE_LIMIT)))
        starve_next = starve_cnt + CNT_W'(1);
    end

    if_valid = (resp_src == RESP_IF) & ~if_flush;
    if (if_valid) if_inst = mem_rdata;
    d_rvalid = (resp_src == RESP_DATA);
    if (d_rvalid && !err_q) d_rdata = mem_rdata;
  end

endmodule
